// File: rtl/multi_pattern_sequence_detector.sv
// multi_pattern_sequence_detector
//   Mealy serial pattern detector. The incoming bit stream is compared against
//   NUM_PAT runtime-programmable FRAME_LEN-bit patterns. In framed mode it
//   checks non-overlapping frames, and in sliding mode it checks every
//   FRAME_LEN-bit window.
// Ports
//   clk, rst_n   clock (rising edge), async active-low reset
//   clr          sync flush of history/position/fill and match_cnt
//   in_valid,in  serial bit and its qualifier
//   mode         0 = framed, 1 = sliding; a change flushes the stream state
//   pat_wr, pat_idx, pat_data   pattern slot write (MSB = first bit received)
//   pat_en       per-slot enable mask, applied combinationally
//   dec, dec_id  same-cycle match flag and lowest matching slot
//   frame_end    framed mode: last bit of a frame accepted this cycle
//   match_cnt    saturating count of dec pulses
module multi_pattern_sequence_detector #(
  parameter int FRAME_LEN = 4,
  parameter int NUM_PAT   = 3,
  parameter int CNT_W     = 8,
  parameter logic [NUM_PAT*FRAME_LEN-1:0] PAT_INIT = 12'b1110_0111_1001,
  localparam int IDW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic                 in,
  input  logic                 mode,
  input  logic                 pat_wr,
  input  logic [IDW-1:0]       pat_idx,
  input  logic [FRAME_LEN-1:0] pat_data,
  input  logic [NUM_PAT-1:0]   pat_en,
  output logic                 dec,
  output logic [IDW-1:0]       dec_id,
  output logic                 frame_end,
  output logic [CNT_W-1:0]     match_cnt
);

  localparam int PW = $clog2(FRAME_LEN);
  localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);

  logic [FRAME_LEN-2:0] hist_q, hist_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic [PW-1:0]        fill_q, fill_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mode_q;
  logic [NUM_PAT-1:0][FRAME_LEN-1:0] pat_q, pat_d;

  logic [FRAME_LEN-1:0] cand;
  logic [NUM_PAT-1:0]   hit;
  logic                 active;
  logic                 eval;

  // The candidate word is the stored history plus the bit arriving now, so
  // a match is flagged in the same cycle as the final bit.
  assign cand = {hist_q, in};

  for (genvar k = 0; k < NUM_PAT; k++) begin : g_cmp
    assign hit[k] = pat_en[k] && (pat_q[k] == cand);
  end

  // A mode change acts as a flush, so the bit offered in that cycle is dropped.
  assign active = in_valid && !clr && (mode == mode_q);
  assign eval   = mode ? (fill_q == LAST) : (pos_q == LAST);

  assign frame_end = active && !mode && (pos_q == LAST);
  assign match_cnt = cnt_q;

  always_comb begin
    dec    = active && eval && (|hit);
    dec_id = '0;
    // The loop runs downward, so the lowest-index hit is assigned last and wins.
    for (int k = NUM_PAT - 1; k >= 0; k--) begin
      if (hit[k]) dec_id = IDW'(k);
    end
    if (!dec) dec_id = '0;
  end

  always_comb begin
    hist_d = hist_q;
    pos_d  = pos_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    pat_d  = pat_q;
    // Pattern writes are independent of the stream. A comparison made in the
    // same cycle still sees the old slot value.
    if (pat_wr && (32'(pat_idx) < NUM_PAT)) pat_d[pat_idx] = pat_data;
    if (clr) begin
      hist_d = '0;
      pos_d  = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (mode != mode_q) begin
      hist_d = '0;
      pos_d  = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = cand[FRAME_LEN-2:0];
      if (!mode) pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
      if (fill_q != LAST) fill_d = fill_q + 1'b1;
      if (dec && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      pos_q  <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      pat_q  <= PAT_INIT;
    end else begin
      hist_q <= hist_d;
      pos_q  <= pos_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      mode_q <= mode;
      pat_q  <= pat_d;
    end
  end

endmodule

// File: tb/tb_multi_pattern_sequence_detector.sv
module tb_multi_pattern_sequence_detector;
  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, in_bit, mode, pat_wr;
  logic [1:0] pat_idx;
  logic [3:0] pat_data;
  logic [2:0] pat_en;
  logic       dec, frame_end, dec_b, frame_end_b;
  logic [1:0] dec_id, dec_id_b;
  logic [7:0] match_cnt;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  multi_pattern_sequence_detector dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in(in_bit),
    .mode(mode), .pat_wr(pat_wr), .pat_idx(pat_idx), .pat_data(pat_data),
    .pat_en(pat_en), .dec(dec), .dec_id(dec_id), .frame_end(frame_end),
    .match_cnt(match_cnt));

  multi_pattern_sequence_detector #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in(in_bit),
    .mode(mode), .pat_wr(pat_wr), .pat_idx(pat_idx), .pat_data(pat_data),
    .pat_en(pat_en), .dec(dec_b), .dec_id(dec_id_b), .frame_end(frame_end_b),
    .match_cnt(cnt_b));

  // Reference model: bits accepted since the last flush, pattern table,
  // the registered copy of mode, and the two saturating counters.
  bit         q[$];
  logic [3:0] mpat[3];
  logic       mmode_q;
  int         mcnt, mcnt2;
  int         checks = 0, failures = 0;
  logic       last_dec;
  logic [1:0] last_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mcnt = 0; mcnt2 = 0; mmode_q = 1'b0;
    mpat[0] = 4'b1001; mpat[1] = 4'b0111; mpat[2] = 4'b1110;
  endtask

  // Called at a falling edge with inputs already set. It checks the outputs,
  // lets one rising edge pass, updates the model, and returns at the next falling edge.
  task automatic tick();
    logic active, ev, ed, efe;
    logic [1:0] eid;
    logic [3:0] cand;
    int n;
    #1;
    active = in_valid && !clr && (mode === mmode_q);
    n = q.size();
    cand = '0;
    for (int i = 0; i < n; i++) cand = {cand[2:0], q[i]};
    cand = {cand[2:0], in_bit};
    ev  = active && (n == 3);
    ed  = 1'b0; eid = 2'd0;
    if (ev) begin
      for (int k = 0; k < 3; k++) begin
        if (!ed && pat_en[k] && mpat[k] == cand) begin ed = 1'b1; eid = 2'(k); end
      end
    end
    efe = active && !mode && (n == 3);
    chk("dec", 32'(dec), 32'(ed));
    chk("dec_id", 32'(dec_id), 32'(eid));
    chk("frame_end", 32'(frame_end), 32'(efe));
    chk("match_cnt", 32'(match_cnt), 32'(mcnt));
    chk("dec_sat", 32'(dec_b), 32'(ed));
    chk("match_cnt_sat", 32'(cnt_b), 32'(mcnt2));
    last_dec = dec; last_id = dec_id;
    @(posedge clk);
    if (clr) begin
      q.delete(); mcnt = 0; mcnt2 = 0;
    end else if (mode !== mmode_q) begin
      q.delete();
    end else if (in_valid) begin
      q.push_back(in_bit);
      if (!mode && q.size() == 4) q.delete();
      if (mode && q.size() > 3) void'(q.pop_front());
      if (ed) begin
        if (mcnt < 255) mcnt++;
        if (mcnt2 < 3) mcnt2++;
      end
    end
    if (pat_wr && pat_idx < 2'd3) mpat[pat_idx] = pat_data;
    mmode_q = mode;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; tick();
  endtask

  task automatic flush();
    clr = 1'b1; in_valid = 1'b0; tick(); clr = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      in_valid = 1'b1; in_bit = v[i]; tick();
    end
    in_valid = 1'b0;
  endtask

  // Asynchronous reset pulse that starts and ends between rising edges.
  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; pat_wr = 1'b0;
    #1;
    model_reset();
    chk("rst_dec", 32'(dec), 32'd0);
    chk("rst_frame_end", 32'(frame_end), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_cnt_sat", 32'(cnt_b), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0; mode = 1'b0;
    pat_wr = 1'b0; pat_idx = 2'd0; pat_data = 4'd0; pat_en = 3'b111;
    model_reset();
    @(negedge clk);
    do_reset();

    // Default patterns in framed mode: slots 0, 1 and 2 each hit once, and the last frame misses.
    send_bits(32'b1001_0111_1110_1100, 16);
    chk("t1_last_nodec", 32'(last_dec), 32'd0);
    idle();
    chk("t1_cnt", 32'(match_cnt), 32'd3);

    // A 1-bit slip in framed mode gives no match. In sliding mode the same stream matches.
    flush();
    send_bits(32'b01001, 5);
    idle();
    chk("t2_framed_cnt", 32'(match_cnt), 32'd0);
    mode = 1'b1; idle();
    send_bits(32'b01001, 5);
    chk("t2_slide_dec", 32'(last_dec), 32'd1);
    chk("t2_slide_id", 32'(last_id), 32'd0);

    // Overlapping matches in sliding mode.
    flush();
    send_bits(32'b1001001, 7);
    idle();
    chk("t3_cnt", 32'(match_cnt), 32'd2);

    // Priority among slots, then the enable mask.
    flush();
    pat_wr = 1'b1; pat_idx = 2'd1; pat_data = 4'b1001; idle(); pat_wr = 1'b0;
    pat_en = 3'b011;
    send_bits(32'b1001, 4);
    chk("t4_prio_dec", 32'(last_dec), 32'd1);
    chk("t4_prio_id", 32'(last_id), 32'd0);
    pat_en = 3'b010; flush();
    send_bits(32'b1001, 4);
    chk("t4_mask_id", 32'(last_id), 32'd1);
    pat_wr = 1'b1; pat_idx = 2'd1; pat_data = 4'b0111; idle(); pat_wr = 1'b0;
    pat_en = 3'b111;

    // Reset mid-frame drops the partial frame. Valid gaps do not break a frame.
    mode = 1'b0; idle();
    send_bits(32'b11, 2);
    do_reset();
    send_bits(32'b1110, 4);
    chk("t5_dec", 32'(last_dec), 32'd1);
    chk("t5_id", 32'(last_id), 32'd2);
    for (int i = 3; i >= 0; i--) begin
      in_valid = 1'b1; in_bit = (i != 0); tick();
      if (i != 0) idle();
    end
    chk("t5_gap_id", 32'(last_id), 32'd2);
    idle();
    chk("t5_cnt", 32'(match_cnt), 32'd2);

    // The 2-bit counter saturates. A clr mid-frame realigns the frame.
    flush();
    for (int i = 0; i < 5; i++) send_bits(32'b1001, 4);
    idle();
    chk("t6_sat", 32'(cnt_b), 32'd3);
    chk("t6_cnt", 32'(match_cnt), 32'd5);
    send_bits(32'b10, 2);
    flush();
    send_bits(32'b1001, 4);
    chk("t6_realign_dec", 32'(last_dec), 32'd1);
    idle();
    chk("t6_clr_cnt", 32'(match_cnt), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom % 4) != 0;
      in_bit   = 1'($urandom);
      clr      = ($urandom % 60) == 0;
      if (($urandom % 40) == 0) mode = ~mode;
      pat_wr   = ($urandom % 16) == 0;
      pat_idx  = 2'($urandom);
      pat_data = 4'($urandom);
      pat_en   = (($urandom % 3) == 0) ? 3'($urandom) : 3'b111;
      tick();
    end
    clr = 1'b0; pat_wr = 1'b0; in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
